max7219_refresh_ctrl: RTL and testbench
=======================================

Name: max7219_refresh_ctrl

Overview:
Sequencer that drives the max7219_settings write engine.
- After reset it issues the 5-register config burst.
- It then scans NUM_DIGITS digit writes on each refresh request, and re-issues config whenever new settings are requested.
- Sits between clock/display logic and max7219_settings, and owns that engine's stb/busy/ack handshake.

Parameters:
NUM_DIGITS, 6, digits scanned per frame (1..8); drives o_scan_limit = NUM_DIGITS-1
STARTUP_CYCLES, 16, idle cycles after reset before the first config burst (power-up settle)
TIMEOUT_CYCLES, 255, ack watchdog limit (only with MAX7219_CTRL_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock (~50MHz)
i_reset_n  in  1  asynchronous reset, active low
i_refresh  in  1  single-cycle pulse: request a full digit frame
i_digits  in  8*NUM_DIGITS  segment patterns; digit k at bits [8k+7:8k]
i_cfg_req  in  1  single-cycle pulse: config inputs changed, rewrite config
i_intensity  in  4  requested intensity
i_enable  in  1  requested display enable (shutdown register)
i_display_test  in  1  requested display-test bit
o_stb  out  1  write strobe to max7219_settings i_stb
i_busy  in  1  from max7219_settings o_busy
i_ack  in  1  from max7219_settings o_ack
o_write_config  out  1  to i_write_config
o_digit  out  3  to i_digit
o_segment  out  8  to i_segment
o_decode_mode  out  8  fixed 8'h00 (no BCD decode)
o_intensity  out  4  latched intensity
o_scan_limit  out  3  constant NUM_DIGITS-1
o_enable  out  1  latched enable
o_display_test  out  1  latched display-test bit
o_idle  out  1  high in IDLE with nothing pending
o_frame_done  out  1  one-cycle pulse after the last digit ack of a frame
o_error  out  1  one-cycle pulse on watchdog abort (tied 0 without the feature)

Behaviour:
- Reset (async assert, sync release):
  - State STARTUP; startup counter 0; cfg_pending=1; refresh_pending=0.
  - Outputs: o_stb=0, o_write_config=0, o_digit=0, o_segment=0, o_intensity=0, o_enable=0, o_display_test=0, o_frame_done=0, o_error=0, o_idle=0.
- States: STARTUP, IDLE, CFG_ISSUE, CFG_WAIT, DIG_ISSUE, DIG_WAIT.
- STARTUP: count to STARTUP_CYCLES-1, then go to IDLE.
- Pending flags:
  - i_cfg_req sets cfg_pending; i_refresh sets refresh_pending. Both are sticky, so repeated pulses coalesce.
  - A flag clears on entry to CFG_ISSUE or DIG_ISSUE(digit 0) respectively.
  - A same-cycle set outranks the clear: the request is re-queued.
- IDLE arbitration: cfg_pending wins over refresh_pending. Both flags are evaluated only in IDLE, so config never interrupts a frame.
- CFG_ISSUE:
  - On entry, latch i_intensity/i_enable/i_display_test into the o_ registers.
  - Drive o_write_config=1 and o_stb=1 while i_busy=0 (exactly one cycle), then go to CFG_WAIT.
- CFG_WAIT: hold o_write_config; o_stb=0. On i_ack go to IDLE and drop o_write_config.
- Frame start:
  - Snapshot all of i_digits into an internal frame buffer on entry to DIG_ISSUE with digit 0. This prevents tearing if inputs change mid-frame.
  - Digit index is 0..NUM_DIGITS-1.
- DIG_ISSUE: o_write_config=0; o_digit=index; o_segment=buffer[index]; o_stb=1 for one cycle while i_busy=0; then go to DIG_WAIT.
- DIG_WAIT: on i_ack, either increment the index and return to DIG_ISSUE, or, if index==NUM_DIGITS-1, pulse o_frame_done, reset the index to 0 and go to IDLE.
- Handshake rules:
  - o_stb is never asserted while i_busy=1 or in any WAIT state.
  - o_digit, o_segment and o_write_config are stable from the o_stb cycle until the ack.
- Throughput: one digit write per engine transaction plus 1 cycle of ISSUE overhead.
- i_refresh during a frame sets refresh_pending; the next frame starts immediately after IDLE.
- Reset mid-transfer aborts to STARTUP; the full config is rewritten afterward.

Optional Feature:
MAX7219_CTRL_TIMEOUT_EN:
- Defined: a watchdog counter runs in CFG_WAIT and DIG_WAIT. If it reaches TIMEOUT_CYCLES without i_ack:
  - pulse o_error
  - set cfg_pending
  - clear refresh_pending
  - reset digit index to 0
  - go to IDLE
  The counter clears on each ISSUE.
- Undefined: WAIT states wait indefinitely; o_error is constant 0; no counter logic.

Decomposition:
- Shared include/package max7219_defs:
  - state encodings
  - register address localparams (DECODE_MODE 9, INTENSITY A, SCAN_LIMIT B, SHUTDOWN C, DISPLAY_TEST F)
  - digit/segment widths
- No sub-module; the frame buffer and counters are inline.
- max7219_settings is instantiated beside this block at top level, not inside it.

Test Plan:
- Reset, then idle with a behavioural engine model (ack 4 cycles after stb):
  - Expect no stb for 16 cycles.
  - Then one stb with o_write_config=1, o_scan_limit=5, o_decode_mode=0.
  - o_idle=1 after the ack.
- i_digits=48'hA1B2C3D4E5F6, pulse i_refresh:
  - Expect 6 stb pulses with o_digit 0..5 and o_segment F6,E5,D4,C3,B2,A1.
  - One o_frame_done after the 6th ack.
- Change i_digits after the digit-1 ack of a frame: expect the remaining digits to use the snapshot values, and the new values only in the next frame.
- Pulse i_cfg_req (intensity=4'h7) and i_refresh in the same cycle: expect the config write first (o_intensity=7), then the digit frame.
- Hold i_busy=1 for 10 cycles while ISSUE is pending: expect o_stb=0 throughout, then exactly one stb once busy drops.
- With MAX7219_CTRL_TIMEOUT_EN, never ack the digit-2 write:
  - Expect an o_error pulse at 255 wait cycles and return to IDLE.
  - Then a config rewrite, and no frame until the next i_refresh.

Source files
------------

// File: rtl/max7219_refresh_ctrl_pkg.sv
// Shared definitions for the MAX7219 refresh sequencer: FSM state encoding,
// MAX7219 register addresses and digit/segment field widths.
package max7219_refresh_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CFG_ISSUE = 3'd2,
    ST_CFG_WAIT  = 3'd3,
    ST_DIG_ISSUE = 3'd4,
    ST_DIG_WAIT  = 3'd5
  } state_e;

  // MAX7219 register map (addresses used by the settings engine)
  localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
  localparam logic [3:0] REG_INTENSITY    = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  localparam int DIGIT_W = 3;
  localparam int SEG_W   = 8;

  // Raw segment patterns are sent, so BCD decode stays off for all digits
  localparam logic [7:0] DECODE_NONE = 8'h00;

endpackage

// File: rtl/max7219_refresh_ctrl.sv
// Refresh sequencer for the max7219_settings write engine. Issues the config
// burst after a power-up settle, scans NUM_DIGITS digits per refresh request
// and rewrites config whenever new settings are requested. Owns the engine's
// stb/busy/ack handshake.
// Optional build macro: MAX7219_CTRL_TIMEOUT_EN adds an ack watchdog that
// aborts a stuck write, pulses o_error and schedules a config rewrite.
module max7219_refresh_ctrl
  import max7219_refresh_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int STARTUP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_refresh,
  input  logic [8*NUM_DIGITS-1:0] i_digits,
  input  logic                    i_cfg_req,
  input  logic [3:0]              i_intensity,
  input  logic                    i_enable,
  input  logic                    i_display_test,
  output logic                    o_stb,
  input  logic                    i_busy,
  input  logic                    i_ack,
  output logic                    o_write_config,
  output logic [2:0]              o_digit,
  output logic [7:0]              o_segment,
  output logic [7:0]              o_decode_mode,
  output logic [3:0]              o_intensity,
  output logic [2:0]              o_scan_limit,
  output logic                    o_enable,
  output logic                    o_display_test,
  output logic                    o_idle,
  output logic                    o_frame_done,
  output logic                    o_error
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 1..8");
  end
  if (STARTUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("STARTUP_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SU_W-1:0]    SU_LAST  = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] LAST_IDX = DIGIT_W'(NUM_DIGITS - 1);

  state_e                  state_q;
  logic [SU_W-1:0]         su_cnt_q;
  logic                    cfg_pend_q;
  logic                    ref_pend_q;
  logic                    wc_q;
  logic [DIGIT_W-1:0]      digit_q;
  logic [SEG_W-1:0]        seg_q;
  logic [3:0]              inten_q;
  logic                    en_q;
  logic                    dt_q;
  logic                    fd_q;
  logic [8*NUM_DIGITS-1:0] frame_q;
  logic [DIGIT_W-1:0]      digit_d;
  logic                    start_frame;
  logic                    wd_expired;

  // Pick one digit's segment byte out of the frame snapshot
  function automatic logic [SEG_W-1:0] seg_at(input logic [8*NUM_DIGITS-1:0] buf_v,
                                              input logic [DIGIT_W-1:0] k);
    logic [SEG_W-1:0] s;
    s = '0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (k == DIGIT_W'(n)) s = buf_v[8*n +: 8];
    end
    return s;
  endfunction

  assign digit_d     = digit_q + 1'b1;
  assign start_frame = (state_q == ST_IDLE) && !cfg_pend_q && ref_pend_q;

  // Strobe is gated by busy combinationally so it can never overlap a busy engine
  assign o_stb = ((state_q == ST_CFG_ISSUE) || (state_q == ST_DIG_ISSUE)) && !i_busy;
  assign o_idle = (state_q == ST_IDLE) && !cfg_pend_q && !ref_pend_q;

  assign o_write_config = wc_q;
  assign o_digit        = digit_q;
  assign o_segment      = seg_q;
  assign o_decode_mode  = DECODE_NONE;
  assign o_intensity    = inten_q;
  assign o_scan_limit   = LAST_IDX;
  assign o_enable       = en_q;
  assign o_display_test = dt_q;
  assign o_frame_done   = fd_q;

`ifdef MAX7219_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            in_wait;

  assign in_wait    = (state_q == ST_CFG_WAIT) || (state_q == ST_DIG_WAIT);
  assign wd_expired = in_wait && !i_ack && (wd_q == WD_LAST);
  assign o_error    = err_q;

  // Ack watchdog: counts wait cycles, restarts from zero on every new write
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= wd_expired;
      if (!in_wait || wd_expired) begin
        wd_q <= '0;
      end else if (!i_ack) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end
`else
  assign wd_expired = 1'b0;
  assign o_error    = 1'b0;
`endif

  // Frame snapshot taken as digit 0 is issued, so the frame never tears
  always_ff @(posedge i_clk) begin
    if (start_frame) frame_q <= i_digits;
  end

  // Sequencer FSM: pending-request arbitration and write issue/wait handshake
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_STARTUP;
      su_cnt_q   <= '0;
      cfg_pend_q <= 1'b1;
      ref_pend_q <= 1'b0;
      wc_q       <= 1'b0;
      digit_q    <= '0;
      seg_q      <= '0;
      inten_q    <= '0;
      en_q       <= 1'b0;
      dt_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      // Requests are sticky; a clear below re-queues if a new pulse lands the same cycle
      if (i_cfg_req) cfg_pend_q <= 1'b1;
      if (i_refresh) ref_pend_q <= 1'b1;

      if (wd_expired) begin
        state_q    <= ST_IDLE;
        cfg_pend_q <= 1'b1;
        ref_pend_q <= i_refresh;
        wc_q       <= 1'b0;
        digit_q    <= '0;
      end else begin
        case (state_q)
          ST_STARTUP: begin
            if (su_cnt_q == SU_LAST) state_q <= ST_IDLE;
            else                     su_cnt_q <= su_cnt_q + 1'b1;
          end
          ST_IDLE: begin
            if (cfg_pend_q) begin
              state_q <= ST_CFG_ISSUE;
              wc_q    <= 1'b1;
              inten_q <= i_intensity;
              en_q    <= i_enable;
              dt_q    <= i_display_test;
              if (!i_cfg_req) cfg_pend_q <= 1'b0;
            end else if (ref_pend_q) begin
              state_q <= ST_DIG_ISSUE;
              wc_q    <= 1'b0;
              digit_q <= '0;
              seg_q   <= i_digits[7:0];
              if (!i_refresh) ref_pend_q <= 1'b0;
            end
          end
          ST_CFG_ISSUE: begin
            if (!i_busy) state_q <= ST_CFG_WAIT;
          end
          ST_CFG_WAIT: begin
            if (i_ack) begin
              state_q <= ST_IDLE;
              wc_q    <= 1'b0;
            end
          end
          ST_DIG_ISSUE: begin
            if (!i_busy) state_q <= ST_DIG_WAIT;
          end
          ST_DIG_WAIT: begin
            if (i_ack) begin
              if (digit_q == LAST_IDX) begin
                fd_q    <= 1'b1;
                digit_q <= '0;
                state_q <= ST_IDLE;
              end else begin
                digit_q <= digit_d;
                seg_q   <= seg_at(frame_q, digit_d);
                state_q <= ST_DIG_ISSUE;
              end
            end
          end
          default: state_q <= ST_STARTUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max7219_refresh_ctrl.sv
// Self-checking bench for max7219_refresh_ctrl with a behavioural write engine
// (busy for 4 cycles, then a one-cycle ack) and a transaction-level model.
module tb_max7219_refresh_ctrl;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          refresh, cfg_req;
  logic [8*ND-1:0] digits;
  logic [3:0]    inten;
  logic          en, dt;
  logic          busy, ack;
  logic          stb, wc, idle, fdone, err;
  logic [2:0]    dig, slim;
  logic [7:0]    seg, dmode;
  logic [3:0]    o_inten;
  logic          o_en, o_dt;

  always #5 clk = ~clk;

  max7219_refresh_ctrl #(.NUM_DIGITS(ND), .STARTUP_CYCLES(16), .TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_refresh(refresh), .i_digits(digits),
    .i_cfg_req(cfg_req), .i_intensity(inten), .i_enable(en), .i_display_test(dt),
    .o_stb(stb), .i_busy(busy), .i_ack(ack), .o_write_config(wc), .o_digit(dig),
    .o_segment(seg), .o_decode_mode(dmode), .o_intensity(o_inten), .o_scan_limit(slim),
    .o_enable(o_en), .o_display_test(o_dt), .o_idle(idle), .o_frame_done(fdone),
    .o_error(err)
  );

  typedef struct packed {
    logic       wc;
    logic [2:0] dig;
    logic [7:0] seg;
    logic [3:0] inten;
    logic       en;
    logic       dt;
  } txn_t;

  typedef struct {
    bit          c;
    bit          r;
    logic [3:0]  i;
    logic        e;
    logic        d;
    logic [47:0] g;
    int          exp_n;
    int          exp_frames;
    bit          exp_first_wc;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  txn_t got_q[$];
  txn_t exp_q[$];
  int   frames_seen = 0;
  int   err_seen = 0;
  int   fexp;

  // Behavioural write engine
  logic eng_busy = 1'b0;
  logic eng_ack = 1'b0;
  logic force_busy = 1'b0;
  logic block_dig2 = 1'b0;
  logic cur_block = 1'b0;
  int   eng_cnt = 0;
  bit   stb_seen = 1'b0;
  txn_t stb_txn;

  assign busy = eng_busy | force_busy;
  assign ack  = eng_ack;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  always @(posedge clk) begin
    eng_ack <= 1'b0;
    if (stb_seen) begin
      eng_busy  <= 1'b1;
      eng_cnt   <= 4;
      cur_block <= block_dig2 && !stb_txn.wc && (stb_txn.dig == 3'd2);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_busy <= 1'b0;
        eng_ack  <= !cur_block;
      end
    end
  end

  // Monitor: log strobes, check hold stability during the engine transaction
  always @(negedge clk) begin
    stb_seen = (stb === 1'b1);
    if (stb === 1'b1) begin
      stb_txn = '{wc, dig, seg, o_inten, o_en, o_dt};
      got_q.push_back(stb_txn);
      check("stb_while_busy", {63'd0, busy}, 64'd0);
    end else if (eng_busy && rst_n && got_q.size() > 0) begin
      check("hold_wc", {63'd0, wc}, {63'd0, got_q[$].wc});
      if (!got_q[$].wc) begin
        check("hold_digit", {61'd0, dig}, {61'd0, got_q[$].dig});
        check("hold_segment", {56'd0, seg}, {56'd0, got_q[$].seg});
      end
    end
    if (fdone === 1'b1) frames_seen++;
    if (err === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      if (idle === 1'b1) ok = 1'b1;
      else tick();
    end
    if (!ok) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  function automatic int n_dig();
    int n;
    n = 0;
    foreach (got_q[k]) if (!got_q[k].wc) n++;
    return n;
  endfunction

  function automatic void push_cfg(input logic [3:0] i, input logic e, input logic d);
    exp_q.push_back('{1'b1, 3'd0, 8'd0, i, e, d});
  endfunction

  function automatic void push_digits(input logic [47:0] g, input int upto);
    for (int k = 0; k < upto; k++) exp_q.push_back('{1'b0, 3'(k), g[8*k +: 8], 4'd0, 1'b0, 1'b0});
  endfunction

  task automatic begin_episode();
    got_q.delete();
    exp_q.delete();
    fexp = 0;
  endtask

  task automatic finish_episode(input int f0, input string tag);
    int n;
    wait_idle();
    tick();
    tick();
    check({tag, " txn_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s txn%0d wc", tag, k), {63'd0, got_q[k].wc}, {63'd0, exp_q[k].wc});
      if (exp_q[k].wc) begin
        check($sformatf("%s txn%0d cfg", tag, k),
              {58'd0, got_q[k].inten, got_q[k].en, got_q[k].dt},
              {58'd0, exp_q[k].inten, exp_q[k].en, exp_q[k].dt});
      end else begin
        check($sformatf("%s txn%0d digit", tag, k), {61'd0, got_q[k].dig}, {61'd0, exp_q[k].dig});
        check($sformatf("%s txn%0d segment", tag, k), {56'd0, got_q[k].seg}, {56'd0, exp_q[k].seg});
      end
    end
    check({tag, " frame_done_count"}, 64'(frames_seen - f0), 64'(fexp));
  endtask

  task automatic pulse(input bit c, input bit r);
    cfg_req = c;
    refresh = r;
    tick();
    cfg_req = 1'b0;
    refresh = 1'b0;
  endtask

  // One request episode from idle, with an optional second request mid-frame
  task automatic run_episode(input bit c, input bit r, input logic [3:0] i1, input logic e1,
                             input logic d1, input logic [47:0] g1, input bit mid, input bit mc,
                             input logic [3:0] i2, input logic e2, input logic d2,
                             input logic [47:0] g2, input int after, input int mw,
                             input string tag);
    int f0;
    bit ok;
    begin_episode();
    f0 = frames_seen;
    inten = i1; en = e1; dt = d1; digits = g1;
    pulse(c, r);
    if (c) push_cfg(i1, e1, d1);
    if (r) begin push_digits(g1, ND); fexp++; end
    if (mid && r) begin
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
        if (n_dig() >= after) ok = 1'b1;
        else tick();
      end
      if (!ok) check({tag, " wait_digit_timeout"}, 64'd1, 64'd0);
      repeat (mw) tick();
      inten = i2; en = e2; dt = d2; digits = g2;
      pulse(mc, 1'b1);
      if (mc) push_cfg(i2, e2, d2);
      push_digits(g2, ND);
      fexp++;
    end
    finish_episode(f0, tag);
    if (mid && r && mc) check({tag, " o_intensity"}, {60'd0, o_inten}, {60'd0, i2});
    else if (c)         check({tag, " o_intensity"}, {60'd0, o_inten}, {60'd0, i1});
  endtask

  vec_t tbl[5];

  initial begin
    int first;
    int f0;
    tbl[0] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 48'hA1B2C3D4E5F6, 6, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 48'h112233445566, 7, 1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 48'h000000000000, 1, 0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 48'h000000000000, 1, 0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 48'hFFFF00FF0080, 6, 1, 1'b0};

    rst_n = 1'b0; refresh = 1'b0; cfg_req = 1'b0;
    digits = '0; inten = 4'h0; en = 1'b0; dt = 1'b0;
    #22;
    check("rst o_stb", {63'd0, stb}, 64'd0);
    check("rst o_write_config", {63'd0, wc}, 64'd0);
    check("rst o_digit", {61'd0, dig}, 64'd0);
    check("rst o_segment", {56'd0, seg}, 64'd0);
    check("rst o_intensity", {60'd0, o_inten}, 64'd0);
    check("rst o_enable", {63'd0, o_en}, 64'd0);
    check("rst o_display_test", {63'd0, o_dt}, 64'd0);
    check("rst o_frame_done", {63'd0, fdone}, 64'd0);
    check("rst o_error", {63'd0, err}, 64'd0);
    check("rst o_idle", {63'd0, idle}, 64'd0);
    check("o_scan_limit", {61'd0, slim}, 64'd5);
    check("o_decode_mode", {56'd0, dmode}, 64'd0);

    // Startup: quiet settle, then the config burst
    @(posedge clk);
    #1 rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      tick();
      if (got_q.size() > 0) first = k;
    end
    check("startup quiet 16 cycles", {63'd0, (first > 16)}, 64'd1);
    check("startup stb arrives", {63'd0, (first > 0 && first <= 24)}, 64'd1);
    if (got_q.size() > 0) check("startup stb is config", {63'd0, got_q[0].wc}, 64'd1);
    wait_idle();
    check("idle after config ack", {63'd0, idle}, 64'd1);
    check("startup single write", 64'(got_q.size()), 64'd1);

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      run_episode(tbl[v].c, tbl[v].r, tbl[v].i, tbl[v].e, tbl[v].d, tbl[v].g,
                  1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 48'h0, 0, 0, $sformatf("tbl%0d", v));
      check($sformatf("tbl%0d n_txn", v), 64'(got_q.size()), 64'(tbl[v].exp_n));
      if (got_q.size() > 0)
        check($sformatf("tbl%0d first_wc", v), {63'd0, got_q[0].wc}, {63'd0, tbl[v].exp_first_wc});
    end

    // Snapshot: inputs change after the digit-1 ack; new pattern only in the next frame
    run_episode(1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 48'h0102030405A6, 1'b1, 1'b0,
                4'h3, 1'b1, 1'b1, 48'hF0E0D0C0B0A0, 2, 5, "snapshot");

    // Busy held high while a digit write is pending
    begin_episode();
    f0 = frames_seen;
    digits = 48'h5A5A5A5A5A5A;
    force_busy = 1'b1;
    pulse(1'b0, 1'b1);
    repeat (10) tick();
    check("busy hold no stb", 64'(got_q.size()), 64'd0);
    force_busy = 1'b0;
    push_digits(48'h5A5A5A5A5A5A, ND);
    fexp = 1;
    finish_episode(f0, "busy");

`ifdef MAX7219_CTRL_TIMEOUT_EN
    begin
      int t;
      int e0;
      bit ok;
      begin_episode();
      f0 = frames_seen;
      e0 = err_seen;
      block_dig2 = 1'b1;
      digits = 48'h665544332211;
      inten = 4'h9; en = 1'b1; dt = 1'b0;
      pulse(1'b0, 1'b1);
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
        if (n_dig() >= 3) ok = 1'b1;
        else tick();
      end
      check("timeout digit2 issued", {63'd0, ok}, 64'd1);
      t = 0;
      while (err_seen == e0 && t < 400) begin
        tick();
        t++;
      end
      check("timeout error delay", {63'd0, (t >= 250 && t <= 262)}, 64'd1);
      block_dig2 = 1'b0;
      push_digits(48'h665544332211, 3);
      push_cfg(4'h9, 1'b1, 1'b0);
      fexp = 0;
      finish_episode(f0, "timeout");
      check("timeout error pulses", 64'(err_seen - e0), 64'd1);
      repeat (20) tick();
      check("timeout no frame without refresh", 64'(got_q.size()), 64'd4);
      run_episode(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 48'h0F1E2D3C4B5A, 1'b0, 1'b0,
                  4'h0, 1'b0, 1'b0, 48'h0, 0, 0, "after_timeout");
    end
`endif

    // Randomized episodes against the transaction model
    for (int n = 0; n < 16; n++) begin
      bit c, r, mid, mc;
      c   = 1'($urandom_range(0, 1));
      r   = c ? 1'($urandom_range(0, 1)) : 1'b1;
      mid = 1'($urandom_range(0, 1));
      mc  = 1'($urandom_range(0, 1));
      run_episode(c, r, 4'($urandom), 1'($urandom), 1'($urandom), {16'($urandom), 32'($urandom)},
                  mid, mc, 4'($urandom), 1'($urandom), 1'($urandom),
                  {16'($urandom), 32'($urandom)}, 1, $urandom_range(0, 20),
                  $sformatf("rnd%0d", n));
    end

`ifndef MAX7219_CTRL_TIMEOUT_EN
    check("o_error stays low", 64'(err_seen), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
